pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with a fetch-request handshake toward
// instruction memory. Generates sequential fetch addresses and applies
// exception/jump/branch redirects. A redirect that arrives while a request
// is held by a stall or backpressure is parked, then applied when the
// request is accepted. Misaligned targets are trapped to the exception vector.
module pc_fetch_unit #(
    parameter int          ADDR_W       = 32,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned INC          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              exc,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] seq_pc,
    output logic              redirect_pending,
    output logic              misalign_err
);

    localparam int              LSB       = $clog2(INC);
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] EXC_PC  = ADDR_W'(EXC_VECTOR);
    localparam logic [ADDR_W-1:0] INC_W   = ADDR_W'(INC);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_is_exc;

    logic              fire;
    logic              new_valid;
    logic              new_is_exc;
    logic [ADDR_W-1:0] new_target;
    logic              use_pending;
    logic              eff_valid;
    logic              eff_is_exc;
    logic [ADDR_W-1:0] eff_target;
    logic              eff_misalign;
    logic [ADDR_W-1:0] apply_target;

    assign seq_pc = pc + INC_W;
    assign fire   = pc_valid & imem_ready & ~stall;

    // Pick this cycle's redirect and merge it with any parked one; a parked
    // exception is never overridden by a newer jump or branch.
    always_comb begin
        new_valid    = exc | jump | branch;
        new_is_exc   = exc;
        new_target   = branch_target;
        if (exc) begin
            new_target = EXC_PC;
        end else if (jump) begin
            new_target = jump_target;
        end

        use_pending  = redirect_pending & (~new_valid | (pend_is_exc & ~new_is_exc));
        eff_valid    = new_valid | redirect_pending;
        eff_is_exc   = use_pending ? pend_is_exc : new_is_exc;
        eff_target   = use_pending ? pend_target : new_target;
        eff_misalign = eff_valid & ~eff_is_exc & (|eff_target[LSB-1:0]);
        apply_target = eff_misalign ? EXC_PC : eff_target;
    end

    // Fetch FSM: BOOT issues nothing for one cycle, RUN keeps a request up
    // and only moves pc when that request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= BOOT;
            pc               <= RST_PC;
            pc_valid         <= 1'b0;
            redirect_pending <= 1'b0;
            pend_target      <= '0;
            pend_is_exc      <= 1'b0;
            misalign_err     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state            <= RUN;
                    pc_valid         <= 1'b1;
                    redirect_pending <= 1'b0;
                    misalign_err     <= eff_misalign;
                    if (eff_valid) begin
                        pc <= apply_target;
                    end
                end
                default: begin
                    pc_valid <= 1'b1;
                    if (fire) begin
                        redirect_pending <= 1'b0;
                        misalign_err     <= eff_misalign;
                        pc               <= eff_valid ? apply_target : seq_pc;
                    end else begin
                        misalign_err <= 1'b0;
                        if (eff_valid) begin
                            redirect_pending <= 1'b1;
                            pend_target      <= eff_target;
                            pend_is_exc      <= eff_is_exc;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a table of directed vectors for the
// 32-bit instance plus short hand-written sequences for async reset, a
// redirect during BOOT and address wrap on an 8-bit instance.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch, jump, exc, imem_ready;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, seq_pc;
    logic        pc_valid, redirect_pending, misalign_err;

    logic        jump8, ready8;
    logic [7:0]  jump_target8;
    logic [7:0]  pc8, seq_pc8;
    logic        pc_valid8, pend8, mis8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        exc;
        logic        jump;
        logic [31:0] jtgt;
        logic        branch;
        logic [31:0] btgt;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_pend;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch(branch), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .exc(exc), .imem_ready(imem_ready),
        .pc(pc), .pc_valid(pc_valid), .seq_pc(seq_pc),
        .redirect_pending(redirect_pending), .misalign_err(misalign_err)
    );

    pc_fetch_unit #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .branch(1'b0), .branch_target(8'h00),
        .jump(jump8), .jump_target(jump_target8),
        .exc(1'b0), .imem_ready(ready8),
        .pc(pc8), .pc_valid(pc_valid8), .seq_pc(seq_pc8),
        .redirect_pending(pend8), .misalign_err(mis8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s (row %0d): actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic addRow(input logic st, input logic rdy, input logic ex,
                          input logic jp, input logic [31:0] jt,
                          input logic br, input logic [31:0] bt,
                          input logic [31:0] epc, input logic ev,
                          input logic ep, input logic em);
        vec_t v;
        v.stall = st; v.ready = rdy; v.exc = ex; v.jump = jp; v.jtgt = jt;
        v.branch = br; v.btgt = bt; v.exp_pc = epc; v.exp_valid = ev;
        v.exp_pend = ep; v.exp_mis = em;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        stall         = v.stall;
        imem_ready    = v.ready;
        exc           = v.exc;
        jump          = v.jump;
        jump_target   = v.jtgt;
        branch        = v.branch;
        branch_target = v.btgt;
    endtask

    task automatic idleInputs();
        stall = 0; imem_ready = 1; exc = 0; jump = 0; branch = 0;
        jump_target = '0; branch_target = '0;
    endtask

    task automatic checkAll(input int row, input logic [31:0] epc, input logic ev,
                            input logic ep, input logic em);
        logic [31:0] eseq;
        eseq = epc + 32'd4;
        checkOutput("pc", row, pc, epc);
        checkOutput("pc_valid", row, {31'b0, pc_valid}, {31'b0, ev});
        checkOutput("redirect_pending", row, {31'b0, redirect_pending}, {31'b0, ep});
        checkOutput("misalign_err", row, {31'b0, misalign_err}, {31'b0, em});
        checkOutput("seq_pc", row, seq_pc, eseq);
    endtask

    initial begin
        rst_n = 1'b0;
        idleInputs();
        jump8 = 0; ready8 = 0; jump_target8 = 8'h00;

        //      st rdy exc jmp jtgt          br btgt          pc            v  p  m
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 0, 0); // BOOT->RUN
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 0, 0);
        addRow(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 0, 0); // backpressure
        addRow(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 0, 0);
        addRow(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0010, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 1, 0, 0);
        addRow(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 1, 0, 0); // stall
        addRow(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 1, 0, 0);
        addRow(1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0018, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_001C, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0020, 1, 0, 0);
        addRow(0, 0, 0, 1, 32'h100,      0, 32'h0,        32'h0000_0020, 1, 1, 0); // parked jump
        addRow(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0020, 1, 1, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0100, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0104, 1, 0, 0);
        addRow(0, 1, 1, 1, 32'h200,      1, 32'h300,      32'h0000_0080, 1, 0, 0); // exc wins
        addRow(0, 0, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0080, 1, 1, 0); // park exc
        addRow(0, 1, 0, 0, 32'h0,        1, 32'h300,      32'h0000_0080, 1, 0, 0); // parked exc beats branch
        addRow(0, 0, 0, 0, 32'h0,        1, 32'h300,      32'h0000_0080, 1, 1, 0); // park branch
        addRow(0, 1, 0, 1, 32'h200,      0, 32'h0,        32'h0000_0200, 1, 0, 0); // new jump beats parked branch
        addRow(0, 1, 0, 0, 32'h0,        1, 32'h102,      32'h0000_0080, 1, 0, 1); // misaligned branch
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0084, 1, 0, 0); // pulse lasts one cycle
        addRow(0, 1, 1, 0, 32'h0,        0, 32'h0,        32'h0000_0080, 1, 0, 0); // exception not flagged
        addRow(0, 0, 0, 0, 32'h0,        1, 32'h206,      32'h0000_0080, 1, 1, 0); // park misaligned
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0080, 1, 0, 1); // trapped at apply
        addRow(0, 1, 0, 1, 32'h7FF0,     0, 32'h0,        32'h0000_7FF0, 1, 0, 0);
        addRow(0, 1, 0, 1, 32'hFFFF_FFFC,0, 32'h0,        32'hFFFF_FFFC, 1, 0, 0);
        addRow(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 1, 0, 0); // 32-bit wrap

        tick();
        tick();
        checkAll(-1, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        checkAll(-2, 32'h0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            checkAll(i, vecs[i].exp_pc, vecs[i].exp_valid, vecs[i].exp_pend, vecs[i].exp_mis);
        end

        // Asynchronous reset while a request and a parked redirect are outstanding
        idleInputs();
        imem_ready = 0; jump = 1; jump_target = 32'h300;
        tick();
        checkAll(100, 32'h0, 1'b1, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checkAll(101, 32'h0, 1'b0, 1'b0, 1'b0);
        idleInputs();
        tick();
        rst_n = 1'b1;
        checkAll(102, 32'h0, 1'b0, 1'b0, 1'b0);

        // Redirect seen in BOOT replaces the reset vector
        jump = 1; jump_target = 32'h40;
        tick();
        checkOutput("boot_redirect_pc", 103, pc, 32'h40);
        checkOutput("boot_redirect_valid", 103, {31'b0, pc_valid}, 32'd1);
        jump = 0;
        tick();
        checkAll(104, 32'h44, 1'b1, 1'b0, 1'b0);

        // 8-bit instance wraps from 0xFC to 0x00
        jump8 = 1; jump_target8 = 8'hFC; ready8 = 1;
        tick();
        checkOutput("wrap8_pc", 105, {24'b0, pc8}, 32'hFC);
        checkOutput("wrap8_seq_pc", 105, {24'b0, seq_pc8}, 32'h00);
        jump8 = 0;
        tick();
        checkOutput("wrap8_pc_next", 106, {24'b0, pc8}, 32'h00);
        checkOutput("wrap8_valid", 106, {31'b0, pc_valid8}, 32'd1);
        checkOutput("wrap8_pend", 106, {31'b0, pend8}, 32'd0);
        checkOutput("wrap8_mis", 106, {31'b0, mis8}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
